// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default line timing,
// kept here so the transmit side can reuse the same constants.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;
  localparam int          CNT_W        = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte-level output bundle of the UART receiver; the receiver drives it
// through the master modport, the display stage reads it through the slave one.
interface uart_byte_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  modport master (output rx_data, rx_valid, frame_err, rx_busy);
  modport slave  (input  rx_data, rx_valid, frame_err, rx_busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen per use so an idle line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: samples each bit at its centre, keeps the last good byte
// on rx_data and reports each frame with a one-clock rx_valid or frame_err.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_byte_rx_if.master rx_if
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             rx_s;
  logic             rx_s_q;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Status pulses default low each cycle; only the STOP sample raises one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_s_q      <= 1'b1;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_s_q      <= rx_s;
      case (state)
        IDLE: begin
          if (rx_s_q && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              rx_data_q  <= shift;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = (state != IDLE);

endmodule
